countdown_chain: RTL
====================

# countdown_chain

Parametrised multi-digit countdown core for the countdown timer. It chains DIGITS loadable down-counting digits, each with its own modulo; the default is MM:SS, with moduli 6,10,6,10. A start/stop/expire state machine gates the count. The block supports one-shot or auto-reload operation and flags expiry with a single-cycle pulse. It sits between the 1 Hz tick prescaler and the display/alarm logic.

## Interface
- DIGITS, 4, number of chained digits
- DIGIT_BITS, 4, width of each digit field
- MODULI, 16'h6A6A, packed per-digit moduli, digit 0 in the LSBs; each 2..2^DIGIT_BITS
- INIT_VAL, 0, reset value of Q and of the reload register
- WRAP, 0, 0 = one-shot (stop at zero); 1 = auto-reload
- CLK  in  1  clock; all logic on the rising edge
- CLR_N  in  1  asynchronous active-low reset
- TICK  in  1  count enable, one-cycle pulse per count period
- START  in  1  request run
- STOP  in  1  request pause
- LOAD  in  1  load LOAD_VAL into Q and into the reload register
- LOAD_VAL  in  DIGITS*DIGIT_BITS  value to load
- Q  out  DIGITS*DIGIT_BITS  current count, registered
- RUN  out  1  high in RUNNING
- EXP  out  1  high in EXPIRED
- ZERO  out  1  combinational, Q == 0
- DONE  out  1  registered one-cycle expiry pulse

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Reset values: Q = INIT_VAL, reload register = INIT_VAL, state = IDLE, RUN = 0, EXP = 0, DONE = 0.
- Control priority per cycle: LOAD > STOP > START > TICK.
- LOAD, from any state: Q and the reload register take LOAD_VAL; state goes to IDLE.
  - Any digit field >= its modulo is clamped to modulo-1 on load.
- START in IDLE or PAUSED with Q != 0: go to RUNNING.
  - START with Q == 0, or in EXPIRED: ignored.
- STOP in RUNNING: go to PAUSED. STOP in any other state: no effect.
- START and STOP in the same cycle: STOP wins.
- Counting happens only in RUNNING on TICK, and only in a cycle with no LOAD, STOP or START.
- Digit i decrements when TICK is high and all digits below i are zero (borrow chain).
  - A digit at 0 that receives a borrow wraps to MODULI[i]-1.
- Expiry tick: a TICK where Q would become all-zero.
  - WRAP=0: Q becomes 0, state goes to EXPIRED, DONE pulses. Later TICKs are ignored until LOAD.
  - WRAP=1: Q takes the reload register instead of 0, state stays RUNNING, DONE pulses. Q never shows zero. Period = reload value in ticks.
- Reload value 0 with WRAP=1: START is ignored, so the block cannot free-run.

## Timing
- Q, state, RUN, EXP and DONE update on the same CLK edge that samples the control inputs; latency is 1 cycle.
- DONE is high for exactly the cycle following the expiry edge, concurrent with Q == 0 (WRAP=0).
- DONE never asserts for two consecutive cycles.
- Back-to-back TICKs on consecutive cycles are legal; each one counts.
- CLR_N low forces all reset values immediately, without a clock edge, including mid-run.
- Release of CLR_N is synchronised externally.

## Structure
- Shared header countdown_defs.vh holds:
  - state encodings: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, EXPIRED=2'd3
  - the default MODULI constant for MM:SS
- Sub-module cnt_digit: one loadable down-counting digit.
  - Ports: CLK, CLR_N, LOAD, D, BIN, Q, BOUT.
  - Parameters: MODULO, BITS, INIT.
  - Instantiated DIGITS times with a generate loop; the load clamp lives here.
- The top level holds the state machine, the reload register, the expiry detect and the DONE register.

## Test plan
- LOAD 16'h0100, START, one TICK -> Q = 16'h0059, RUN=1, DONE=0.
- LOAD 16'h0002, START, two TICKs -> Q = 0, EXP=1, DONE high for one cycle; a third TICK leaves Q = 0.
- WRAP=1, LOAD 16'h0003, START, three TICKs -> Q goes 2, 1, 3. DONE pulses on the third; RUN stays 1.
- RUNNING at 16'h0010, STOP together with TICK -> Q unchanged, PAUSED. START then TICK -> Q = 16'h0009.
- LOAD 16'h0F7C -> Q = 16'h0959 (clamped); START with Q=0 after LOAD 0 -> stays IDLE.
- RUNNING at 16'h0030, pull CLR_N low between edges -> Q = INIT_VAL and RUN=0 at once, before the next edge.

Source files
------------

// File: rtl/countdown_chain_pkg.sv
// Shared definitions for the countdown core: FSM encodings and the default MM:SS moduli.
// Latency: n/a (constants only).
// Backpressure: n/a.
package countdown_chain_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_PAUSED  = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;

   // MM:SS, digit 0 in the LSBs: sec units /10, sec tens /6, min units /10, min tens /6
   localparam logic [15:0] DEFAULT_MODULI = 16'h6A6A;

endpackage

// File: rtl/countdown_chain_cnt_digit.sv
// One loadable down-counting digit with a borrow chain; out-of-range loads clamp to MODULO-1.
// Latency: 1 cycle from LOAD/BIN to Q.
// Backpressure: none; LOAD overrides the borrow in the same cycle.
module cnt_digit #(
   parameter int            MODULO = 10,
   parameter int            BITS   = 4,
   parameter logic [BITS-1:0] INIT = '0
) (
   input  logic            CLK,
   input  logic            CLR_N,
   input  logic            LOAD,
   input  logic [BITS-1:0] D,
   input  logic            BIN,
   output logic [BITS-1:0] Q,
   output logic            BOUT
);

   localparam logic [BITS-1:0] MAX_VAL = BITS'(MODULO - 1);
   localparam logic [BITS:0]   MOD_W   = (BITS+1)'(MODULO);

   logic [BITS-1:0] q_q, q_d;

   // Next value: clamped load first, otherwise decrement with wrap on an incoming borrow
   always_comb begin
      q_d = q_q;
      if (LOAD) begin
         q_d = ({1'b0, D} >= MOD_W) ? MAX_VAL : D;
      end else if (BIN) begin
         q_d = (q_q == '0) ? MAX_VAL : q_q - 1'b1;
      end
   end

   // Digit register, cleared straight to INIT by the asynchronous reset
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) q_q <= INIT;
      else        q_q <= q_d;
   end

   assign Q    = q_q;
   // A digit sitting at zero that is asked to decrement borrows from the next digit up
   assign BOUT = BIN && (q_q == '0);

endmodule

// File: rtl/countdown_chain.sv
// Multi-digit countdown with start/stop/expire FSM, reload register and a one-cycle DONE pulse.
// Latency: 1 cycle from control inputs to Q/RUN/EXP/DONE; ZERO is combinational on Q.
// Backpressure: none; per-cycle priority LOAD > STOP > START > TICK.
module countdown_chain
   import countdown_chain_pkg::*;
#(
   parameter int                            DIGITS     = 4,
   parameter int                            DIGIT_BITS = 4,
   parameter logic [DIGITS*DIGIT_BITS-1:0]  MODULI     = DEFAULT_MODULI,
   parameter logic [DIGITS*DIGIT_BITS-1:0]  INIT_VAL   = '0,
   parameter bit                            WRAP       = 1'b0
) (
   input  logic                         CLK,
   input  logic                         CLR_N,
   input  logic                         TICK,
   input  logic                         START,
   input  logic                         STOP,
   input  logic                         LOAD,
   input  logic [DIGITS*DIGIT_BITS-1:0] LOAD_VAL,
   output logic [DIGITS*DIGIT_BITS-1:0] Q,
   output logic                         RUN,
   output logic                         EXP,
   output logic                         ZERO,
   output logic                         DONE
);

   localparam int W = DIGITS * DIGIT_BITS;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  reload_q, reload_d;
   logic          done_q, done_d;

   logic [W-1:0]  q_w;
   logic [W-1:0]  dig_d;
   logic [DIGITS:0] borrow;
   logic          borrow_unused;
   logic          cnt_en, expire, dig_load, start_ok;

   // A count step only happens in RUNNING on a TICK with no other control in the cycle
   assign cnt_en   = TICK && !LOAD && !STOP && !START && (state_q == ST_RUNNING);
   // The borrow chain can only reach all-zero from exactly 1
   assign expire   = cnt_en && (q_w == W'(1));
   // Auto-reload reuses the digits' load path, so reloads are clamped like any other load
   assign dig_load = LOAD || (WRAP && expire);
   assign dig_d    = LOAD ? LOAD_VAL : reload_q;
   assign borrow[0] = cnt_en;
   assign borrow_unused = borrow[DIGITS];
   // With auto-reload a zero reload value would free-run at zero, so refuse to start
   assign start_ok = !WRAP || (reload_q != '0);

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_digit
         // A zero modulo field stands for the full 2^DIGIT_BITS range
         localparam int M = (MODULI[i*DIGIT_BITS +: DIGIT_BITS] == '0) ?
                            (1 << DIGIT_BITS) : int'(MODULI[i*DIGIT_BITS +: DIGIT_BITS]);
         cnt_digit #(
            .MODULO (M),
            .BITS   (DIGIT_BITS),
            .INIT   (INIT_VAL[i*DIGIT_BITS +: DIGIT_BITS])
         ) u_digit (
            .CLK   (CLK),
            .CLR_N (CLR_N),
            .LOAD  (dig_load),
            .D     (dig_d[i*DIGIT_BITS +: DIGIT_BITS]),
            .BIN   (borrow[i]),
            .Q     (q_w[i*DIGIT_BITS +: DIGIT_BITS]),
            .BOUT  (borrow[i+1])
         );
      end
   endgenerate

   // FSM, reload capture and DONE pulse generation, in control-priority order
   always_comb begin
      state_d  = state_q;
      reload_d = reload_q;
      // Suppressing a repeat keeps DONE single-cycle even with a reload of 1 and back-to-back ticks
      done_d   = expire && !done_q;
      if (LOAD) begin
         state_d  = ST_IDLE;
         reload_d = LOAD_VAL;
      end else if (STOP) begin
         if (state_q == ST_RUNNING) state_d = ST_PAUSED;
      end else if (START) begin
         if (((state_q == ST_IDLE) || (state_q == ST_PAUSED)) && (q_w != '0) && start_ok)
            state_d = ST_RUNNING;
      end else if (expire && !WRAP) begin
         state_d = ST_EXPIRED;
      end
   end

   // Control registers, forced to reset values asynchronously
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q  <= ST_IDLE;
         reload_q <= INIT_VAL;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign Q    = q_w;
   assign ZERO = (q_w == '0);
   assign RUN  = (state_q == ST_RUNNING);
   assign EXP  = (state_q == ST_EXPIRED);
   assign DONE = done_q;

endmodule
